// File: rtl/mem_rd_ctrl_pkg.sv
// mem_rd_pkg: shared FSM state type and output buffer depth for the packet read controller
package mem_rd_pkg;
  typedef enum logic [1:0] {IDLE, READ, CLEAR, WAIT} rd_state_t;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/mem_rd_ctrl_if.sv
// mem_rd_ctrl_if: writer handshake, RAM read port and output stream of the read controller
interface mem_rd_ctrl_if #(parameter int AWIDTH = 4, parameter int DWIDTH = 8);
  logic              busy_i;
  logic [AWIDTH-1:0] wraddr_i;
  logic [AWIDTH-1:0] rdaddr_o;
  logic [DWIDTH-1:0] rddata_i;
  logic [DWIDTH-1:0] data_o;
  logic              val_o;
  logic              sop_o;
  logic              eop_o;
  logic              ready_i;
  logic              clr_o;
  modport slave (input busy_i, wraddr_i, rddata_i, ready_i,
                 output rdaddr_o, data_o, val_o, sop_o, eop_o, clr_o);
  modport master (output busy_i, wraddr_i, rddata_i, ready_i,
                  input rdaddr_o, data_o, val_o, sop_o, eop_o, clr_o);
endinterface

// File: rtl/mem_rd_ctrl_skid_fifo.sv
// rd_skid_fifo: two-entry buffer absorbing RAM read data under output backpressure
module rd_skid_fifo import mem_rd_pkg::*; #(parameter int W = 10) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wr_idx;
  // slot for the incoming word, after any simultaneous pop has shifted the head out
  assign wr_idx = cnt[0] ^ pop;
  assign dout = mem[0];
  always_ff @(posedge clk_i or posedge srst_i)
    if (srst_i) begin
      mem <= '{default: '0};
      cnt <= '0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (pop) mem[0] <= mem[1];
      if (push) mem[wr_idx] <= din;
    end
endmodule

// File: rtl/mem_rd_ctrl.sv
// mem_rd_ctrl: drains a stored packet from RAM into a sop/eop framed valid/ready stream,
// then pulses clr_o to release the writer
module mem_rd_ctrl import mem_rd_pkg::*; #(parameter int AWIDTH = 4, parameter int DWIDTH = 8) (
  input logic          clk_i,
  input logic          srst_i,
  mem_rd_ctrl_if.slave bus
);
  rd_state_t         state;
  logic [AWIDTH:0]   len, issued;
  logic [AWIDTH-1:0] rdaddr;
  logic              inflight, tag_sop, tag_eop;
  logic [1:0]        cnt;
  logic [2:0]        occ;
  logic [DWIDTH+1:0] head;
  logic              pop, issue;
  assign pop = bus.val_o && bus.ready_i;
  // occupancy after this cycle's pop, so a draining buffer sustains one word per clock
  assign occ = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
  assign issue = state == READ && issued < len && occ < 3'(FIFO_DEPTH);
  always_ff @(posedge clk_i or posedge srst_i)
    if (srst_i) begin
      state    <= IDLE;
      len      <= '0;
      issued   <= '0;
      rdaddr   <= '0;
      inflight <= 1'b0;
      tag_sop  <= 1'b0;
      tag_eop  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rdaddr  <= rdaddr + 1'b1;
        issued  <= issued + 1'b1;
        tag_sop <= issued == '0;
        tag_eop <= issued == len - 1'b1;
      end
      case (state)
        IDLE: if (bus.busy_i) begin
          state  <= READ;
          len    <= {bus.wraddr_i == '0, bus.wraddr_i};
          issued <= '0;
          rdaddr <= '0;
        end
        READ:    if (pop && head[DWIDTH]) state <= CLEAR;
        CLEAR:   state <= WAIT;
        WAIT:    if (!bus.busy_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  rd_skid_fifo #(.W(DWIDTH + 2)) u_fifo (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .push   (inflight),
    .pop    (pop),
    .din    ({tag_sop, tag_eop, bus.rddata_i}),
    .dout   (head),
    .cnt    (cnt)
  );
  assign bus.rdaddr_o = rdaddr;
  assign bus.val_o    = cnt != 2'd0;
  assign bus.data_o   = head[DWIDTH-1:0];
  assign bus.sop_o    = bus.val_o && head[DWIDTH+1];
  assign bus.eop_o    = bus.val_o && head[DWIDTH];
  assign bus.clr_o    = state == CLEAR;
endmodule

// File: tb/tb_mem_rd_ctrl.sv
// tb_mem_rd_ctrl: packet-level scoreboard of the read controller against a synchronous RAM model
module tb_mem_rd_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;
  mem_rd_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus();
  mem_rd_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (.clk_i(clk), .srst_i(srst), .bus(bus));
  logic [DW-1:0] ram [16];
  always @(posedge clk) bus.rddata_i <= ram[bus.rdaddr_o];
  int n_chk = 0;
  int n_fail = 0;
  logic [DW+1:0] exp_q [$];
  logic [DW+1:0] w_cmp;
  logic exp_clr = 1'b0;
  logic prev_stall = 1'b0;
  logic [DW+2:0] prev_out;
  logic [AW-1:0] addr_log [64];
  logic [DW-1:0] data_log [64];
  int fv, cc, nv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW+2:0] outs();
    return {bus.val_o, bus.sop_o, bus.eop_o, bus.data_o};
  endfunction

  // every handshake must match the next expected word; clr_o only right after the eop handshake
  always @(negedge clk) begin
    if (srst) begin
      exp_clr = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("clr_o", bus.clr_o, exp_clr);
      if (prev_stall) chk("stall_hold", outs(), prev_out);
      exp_clr = 1'b0;
      if (bus.val_o && bus.ready_i) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w_cmp = exp_q.pop_front();
          chk("word", {bus.sop_o, bus.eop_o, bus.data_o}, w_cmp);
          exp_clr = w_cmp[DW];
        end
      end
      prev_stall = bus.val_o && !bus.ready_i;
      prev_out = outs();
    end
  end

  task automatic run_pkt(input int wr, input int hold, input bit rnd,
                         output int first_val, output int clr_c, output int nval);
    int len, c, issues, acc;
    logic [AW-1:0] last;
    bit done;
    len = (wr == 0) ? 16 : wr;
    for (int i = 0; i < len; i++) exp_q.push_back({i == 0, i == len - 1, ram[i]});
    bus.wraddr_i = AW'(wr);
    bus.busy_i = 1'b1;
    bus.ready_i = 1'b1;
    c = 0; issues = 0; acc = 0; first_val = 0; clr_c = 0; nval = 0; done = 0; last = '0;
    while (!done && c < 300) begin
      @(posedge clk); #2;
      c++;
      if (c < 64) begin
        addr_log[c] = bus.rdaddr_o;
        data_log[c] = bus.data_o;
      end
      if (c == 1) last = bus.rdaddr_o;
      else if (bus.rdaddr_o != last) begin
        issues++;
        last = bus.rdaddr_o;
      end
      chk("outstanding", (issues - acc) <= 2, 1);
      if (bus.val_o) begin
        nval++;
        if (first_val == 0) first_val = c;
      end
      if (bus.clr_o) begin
        clr_c = c;
        done = 1;
      end
      bus.ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.val_o && bus.ready_i) acc++;
    end
    chk("clr_seen", done, 1);
    chk("drained", exp_q.size(), 0);
    repeat (hold) begin
      @(posedge clk); #2;
    end
    bus.busy_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'(i * 17 + 3);
    bus.busy_i = 1'b0;
    bus.wraddr_i = '0;
    bus.ready_i = 1'b1;
    idle(2);
    chk("rst_val", bus.val_o, 0);
    chk("rst_sop", bus.sop_o, 0);
    chk("rst_eop", bus.eop_o, 0);
    chk("rst_clr", bus.clr_o, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_rdaddr", bus.rdaddr_o, 0);
    srst = 1'b0;
    idle(2);
    // five words, full throughput
    run_pkt(5, 0, 0, fv, cc, nv);
    chk("t1_first_val", fv, 3);
    chk("t1_clr_cycle", cc, 8);
    chk("t1_nval", nv, 5);
    for (int k = 1; k <= 5; k++) chk("t1_rdaddr", addr_log[k], k - 1);
    chk("t1_word0", data_log[3], 8'h03);
    chk("t1_word4", data_log[7], 8'h47);
    idle(3);
    // single word carries both sop and eop
    run_pkt(1, 0, 0, fv, cc, nv);
    chk("t2_first_val", fv, 3);
    chk("t2_clr_cycle", cc, 4);
    chk("t2_nval", nv, 1);
    idle(4);
    // wraddr 0 means a full 16-word packet
    run_pkt(0, 0, 0, fv, cc, nv);
    chk("t3_rdaddr_15", addr_log[16], 15);
    chk("t3_rdaddr_wrap", addr_log[17], 0);
    chk("t3_clr_cycle", cc, 19);
    chk("t3_nval", nv, 16);
    idle(3);
    // random backpressure
    run_pkt(6, 0, 1, fv, cc, nv);
    chk("t4_first_val", fv, 3);
    idle(3);
    // busy lingers after clr: no re-read, then a fresh packet
    run_pkt(3, 2, 0, fv, cc, nv);
    idle(3);
    run_pkt(4, 0, 0, fv, cc, nv);
    chk("t5_first_val", fv, 3);
    chk("t5_clr_cycle", cc, 7);
    idle(3);
    // asynchronous reset mid-packet
    for (int i = 0; i < 10; i++) exp_q.push_back({i == 0, i == 9, ram[i]});
    bus.wraddr_i = AW'(10);
    bus.busy_i = 1'b1;
    bus.ready_i = 1'b1;
    idle(5);
    #1 srst = 1'b1;
    #1;
    chk("t6_val", bus.val_o, 0);
    chk("t6_sop", bus.sop_o, 0);
    chk("t6_eop", bus.eop_o, 0);
    chk("t6_clr", bus.clr_o, 0);
    chk("t6_data", bus.data_o, 0);
    chk("t6_rdaddr", bus.rdaddr_o, 0);
    exp_q.delete();
    @(posedge clk); #2;
    srst = 1'b0;
    run_pkt(10, 0, 0, fv, cc, nv);
    chk("t6_restart_first_val", fv, 3);
    chk("t6_restart_addr", addr_log[1], 0);
    chk("t6_restart_word0", data_log[3], 8'h03);
    chk("t6_restart_clr", cc, 13);
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
